// File: rtl/banked_regfile_sb_if.sv
// Issue/write-back side bundle of the banked register file: read ports, write-back,
// scoreboard allocation and the inter-bank move handshake.
interface banked_regfile_sb_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int NUM_BANKS = 2,
  parameter int NUM_RD    = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [NUM_RD*BANK_W-1:0] rd_bank;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;

  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              alloc_en;
  logic [BANK_W-1:0] alloc_bank;
  logic [ADDR_W-1:0] alloc_addr;

  // Move handshake: a request transfers on a rising edge where mv_valid && mv_ready;
  // the requester holds mv_* stable while mv_valid is high and mv_ready is low.
  logic              mv_valid;
  logic              mv_ready;
  logic [BANK_W-1:0] mv_src_bank;
  logic [BANK_W-1:0] mv_dst_bank;
  logic [ADDR_W-1:0] mv_src_addr;
  logic [ADDR_W-1:0] mv_dst_addr;
  logic              mv_done;
  logic              init_done;

  modport master (
    output rd_bank, rd_addr, wr_en, wr_bank, wr_addr, wr_data,
           alloc_en, alloc_bank, alloc_addr,
           mv_valid, mv_src_bank, mv_dst_bank, mv_src_addr, mv_dst_addr,
    input  rd_data, rd_pending, mv_ready, mv_done, init_done
  );

  modport slave (
    input  rd_bank, rd_addr, wr_en, wr_bank, wr_addr, wr_data,
           alloc_en, alloc_bank, alloc_addr,
           mv_valid, mv_src_bank, mv_dst_bank, mv_src_addr, mv_dst_addr,
    output rd_data, rd_pending, mv_ready, mv_done, init_done
  );
endinterface

// File: rtl/banked_regfile_sb.sv
// Banked GPR/FPR register file with pending-write scoreboard, two-cycle move engine
// and post-reset init sweep. Optional same-cycle read bypass: define RF_BYPASS_EN.
module banked_regfile_sb #(
  parameter int          DATA_W    = 32,
  parameter int          NUM_REGS  = 32,
  parameter int          NUM_BANKS = 2,
  parameter int          NUM_RD    = 2,
  parameter bit          ZERO_REG  = 1'b1,
  parameter logic [31:0] SP_INIT   = 32'h80000000,
  parameter logic [31:0] GP_INIT   = 32'h10008000
) (
  input  logic                clk,
  input  logic                reset,
  banked_regfile_sb_if.slave  bus,
  output logic [1:0]          dbg_state_o
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [BANK_W:0]   NB_LIM   = (BANK_W+1)'(NUM_BANKS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_READY = 2'd1,
    S_MV_WR = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0]   mem_q  [NUM_BANKS][NUM_REGS];
  logic [NUM_REGS-1:0] pend_q [NUM_BANKS];
  logic [NUM_REGS-1:0] pend_d [NUM_BANKS];

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [BANK_W-1:0] dst_bank_q, dst_bank_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic              mv_done_q, mv_done_d;
  logic              init_done_q, init_done_d;

  logic sweep_we, wb_we, al_we, mv_we, mv_ready_c;

  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_pend_c;

  function automatic logic bank_ok(input logic [BANK_W-1:0] b);
    return ({1'b0, b} < NB_LIM);
  endfunction

  function automatic logic is_zero(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a);
    return ZERO_REG && (b == '0) && (a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] peek(input logic [BANK_W-1:0] b,
                                             input logic [ADDR_W-1:0] a);
    if (!bank_ok(b) || is_zero(b, a)) return '0;
    return mem_q[b][a];
  endfunction

  // gp/sp only exist in bank 0 and only when the bank is deep enough to hold them.
  function automatic logic [DATA_W-1:0] init_value(input int b, input logic [ADDR_W-1:0] i);
    logic [DATA_W-1:0] v;
    v = '0;
    if (b == 0 && NUM_REGS > 29 && i == ADDR_W'(29)) v = DATA_W'(SP_INIT);
    if (b == 0 && NUM_REGS > 28 && i == ADDR_W'(28)) v = DATA_W'(GP_INIT);
    return v;
  endfunction

  assign wb_we = bus.wr_en && (state_q != S_INIT) && bank_ok(bus.wr_bank)
                 && !is_zero(bus.wr_bank, bus.wr_addr);
  assign al_we = bus.alloc_en && (state_q != S_INIT) && bank_ok(bus.alloc_bank)
                 && !is_zero(bus.alloc_bank, bus.alloc_addr);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    dst_bank_d  = dst_bank_q;
    dst_addr_d  = dst_addr_q;
    mv_done_d   = 1'b0;
    init_done_d = init_done_q;
    sweep_we    = 1'b0;
    mv_we       = 1'b0;
    mv_ready_c  = 1'b0;
    case (state_q)
      S_INIT: begin
        sweep_we = 1'b1;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d     = S_READY;
          init_done_d = 1'b1;
        end
      end
      S_READY: begin
        mv_ready_c = 1'b1;
        if (bus.mv_valid) begin
          hold_d     = peek(bus.mv_src_bank, bus.mv_src_addr);
          dst_bank_d = bus.mv_dst_bank;
          dst_addr_d = bus.mv_dst_addr;
          state_d    = S_MV_WR;
        end
      end
      S_MV_WR: begin
        // The write-back port owns the destination bank this cycle; retry next cycle.
        if (!(bus.wr_en && bus.wr_bank == dst_bank_q)) begin
          mv_we     = bank_ok(dst_bank_q) && !is_zero(dst_bank_q, dst_addr_q);
          mv_done_d = 1'b1;
          state_d   = S_READY;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Clears first, then allocation, so a same-cycle allocate keeps the entry pending.
  always_comb begin
    pend_d = pend_q;
    if (wb_we) pend_d[bus.wr_bank][bus.wr_addr] = 1'b0;
    if (mv_we) pend_d[dst_bank_q][dst_addr_q] = 1'b0;
    if (al_we) pend_d[bus.alloc_bank][bus.alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      hold_q      <= '0;
      dst_bank_q  <= '0;
      dst_addr_q  <= '0;
      mv_done_q   <= 1'b0;
      init_done_q <= 1'b0;
      pend_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      dst_bank_q  <= dst_bank_d;
      dst_addr_q  <= dst_addr_d;
      mv_done_q   <= mv_done_d;
      init_done_q <= init_done_d;
      pend_q      <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      for (int b = 0; b < NUM_BANKS; b++) mem_q[b][idx_q] <= init_value(b, idx_q);
    end
    if (wb_we) mem_q[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
    if (mv_we) mem_q[dst_bank_q][dst_addr_q] <= hold_q;
  end

  always_comb begin
    logic [BANK_W-1:0] b;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              pd;
    rd_data_c = '0;
    rd_pend_c = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      b  = bus.rd_bank[p*BANK_W +: BANK_W];
      a  = bus.rd_addr[p*ADDR_W +: ADDR_W];
      d  = peek(b, a);
      pd = bank_ok(b) ? pend_q[b][a] : 1'b0;
`ifdef RF_BYPASS_EN
      if (wb_we && bus.wr_bank == b && bus.wr_addr == a) begin
        d  = bus.wr_data;
        pd = 1'b0;
      end else if (mv_we && dst_bank_q == b && dst_addr_q == a) begin
        d  = hold_q;
        pd = 1'b0;
      end
`endif
      if (state_q == S_INIT) begin
        d  = '0;
        pd = 1'b0;
      end
      rd_data_c[p*DATA_W +: DATA_W] = d;
      rd_pend_c[p] = pd;
    end
  end

  assign bus.rd_data    = rd_data_c;
  assign bus.rd_pending = rd_pend_c;
  assign bus.mv_ready   = mv_ready_c;
  assign bus.mv_done    = mv_done_q;
  assign bus.init_done  = init_done_q;
  assign dbg_state_o    = state_q;
endmodule

// File: doc/banked_regfile_sb.md
Name: banked_regfile_sb

Overview:
Parametrised successor to the split GPR/FPR register file. Holds NUM_BANKS banks of NUM_REGS x DATA_W registers (bank 0 = GPR, bank 1 = FPR by convention). Provides NUM_RD combinational read ports, one write-back port, a two-cycle inter-bank move engine (mtc1/mfc1 style), a per-entry pending-write scoreboard and a sequential post-reset initialisation sweep. Sits between decode/issue and write-back in the core.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, registers per bank (power of 2, >=2); ADDR_W = clog2(NUM_REGS)
NUM_BANKS, 2, number of banks (>=1); BANK_W = max(1, clog2(NUM_BANKS))
NUM_RD, 2, number of read ports
ZERO_REG, 1, 1 = bank 0 entry 0 is hardwired zero
SP_INIT, 32'h80000000, init value of bank 0 entry 29 (applied if NUM_REGS > 29)
GP_INIT, 32'h10008000, init value of bank 0 entry 28 (applied if NUM_REGS > 28)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
rd_bank  in  NUM_RD*BANK_W  read bank select, packed per port
rd_addr  in  NUM_RD*ADDR_W  read address, packed per port
rd_data  out  NUM_RD*DATA_W  read data, packed per port
rd_pending  out  NUM_RD  scoreboard bit of each read entry
wr_en  in  1  write-back enable
wr_bank  in  BANK_W  write bank
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
alloc_en  in  1  mark entry pending (issue of producer)
alloc_bank  in  BANK_W  bank to mark
alloc_addr  in  ADDR_W  entry to mark
mv_valid  in  1  move request
mv_ready  out  1  move engine can accept
mv_src_bank, mv_dst_bank  in  BANK_W each  move source / destination bank
mv_src_addr, mv_dst_addr  in  ADDR_W each  move source / destination entry
mv_done  out  1  one-cycle pulse: move written
init_done  out  1  init sweep complete

Behaviour:
- Reset (async): FSM -> INIT, sweep counter = 0, scoreboard all 0, move holding reg = 0, mv_done = 0, init_done = 0, mv_ready = 0. Applies mid-move or mid-sweep; an in-flight move is dropped.
- INIT: one entry per cycle, entry[idx] <- 0 in every bank, except bank 0 entries 28/29 <- GP_INIT/SP_INIT. Exactly NUM_REGS cycles after reset deassertion, then READY; init_done = 1 from the following cycle on. During INIT: wr_en, alloc_en and mv_valid are ignored; rd_data = 0; rd_pending = 0.
- Reads: combinational, rd_data = bank[rd_bank][rd_addr]; bank 0 entry 0 reads 0 when ZERO_REG = 1. An out-of-range bank reads 0.
- Write: at posedge when wr_en; writes to the zero register or an out-of-range bank are dropped. Clears the scoreboard bit of the written entry.
- Scoreboard: alloc_en sets the bit at posedge. Same-cycle alloc and clear of one entry -> set wins. Alloc to the zero register is ignored.
- Move FSM states: READY, MV_WR.
  - READY: mv_ready = 1; on mv_valid, capture src entry (array value before this edge's write) into holding, latch dst, go to MV_WR.
  - MV_WR: mv_ready = 0. If wr_en targets dst bank this cycle, the write-back port wins and the move stalls in MV_WR. Otherwise write holding to dst (zero reg dropped), clear dst scoreboard bit, mv_done = 1 next cycle, return to READY.
  - Back-to-back moves: one accepted every 2 cycles minimum.
- Move write and alloc to the same entry in the same cycle -> set wins.

Optional Feature:
RF_BYPASS_EN: when defined, each read port whose bank/addr matches an active wr_en in the same cycle returns wr_data, and a matching pending move write in MV_WR (not stalled) returns holding; rd_pending for that port reads 0. Bypass never applies to the zero register. When not defined, reads see the old value until after the edge, and rd_pending reflects the pre-edge bit.

Test Plan:
- Reset, release, read during sweep: rd_data = 0 and init_done = 0 for 32 cycles; then init_done = 1, bank0[29] = 80000000, bank0[28] = 10008000, bank1[5] = 0.
- Write bank0[0] = DEADBEEF and bank1[0] = 12345678: bank0[0] reads 0, bank1[0] reads 12345678.
- alloc bank0[7] -> rd_pending = 1; write bank0[7] = 55 while alloc bank0[7] in the same cycle -> data 55, pending stays 1; write again -> pending 0.
- Move bank0[3] (= 0000ABCD) -> bank1[4] with wr_en to bank1[9] on the MV_WR cycle: move stalls 1 cycle, then bank1[4] = 0000ABCD, bank1[9] correct, mv_done pulses once.
- Assert reset while in MV_WR: the move never writes, no mv_done, full sweep repeats, scoreboard cleared.
- With RF_BYPASS_EN, read bank1[2] while writing 0F0F0F0F to it: same-cycle rd_data = 0F0F0F0F; without the macro, old value until the next cycle.
